// File: rtl/scsm_pkg.sv
// Shared constants and one-hot helpers for the seven-segment sequence counter.
package scsm_pkg;

    localparam int NUM_ST = 8;
    localparam int ST_W   = 3;
    localparam logic [NUM_ST-1:0] ONEHOT_S0 = 8'b0000_0001;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [NUM_ST-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [ST_W-1:0] onehot_to_bin(input logic [NUM_ST-1:0] v);
        logic [ST_W-1:0] b;
        b = '0;
        if (is_onehot(v)) begin
            for (int i = 0; i < NUM_ST; i++) begin
                if (v[i]) b = ST_W'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running enable prescaler: tick is high for one enabled cycle out of every PRESCALE.
module tick_prescaler #(
    parameter  int PRESCALE = 50_000_000,
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] count_q;
    logic [PS_W-1:0] count_d;

    assign tick = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scsm_counter.sv
// Self-correcting one-hot 8-state counter with binary digit output for the display decoder.
// Define SCSM_FORCE_EN to add force_en/force_val for injecting register patterns.
module scsm_counter
    import scsm_pkg::*;
#(
    parameter int PRESCALE = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
`ifdef SCSM_FORCE_EN
    input  logic              force_en,
    input  logic [NUM_ST-1:0] force_val,
`endif
    output logic [ST_W-1:0]   state,
    output logic              wrap,
    output logic              err
);

    logic              tick;
    logic              legal;
    logic [NUM_ST-1:0] onehot_q, onehot_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    assign legal = is_onehot(onehot_q);

    // Priority below reset: force, then recovery, then step; a tick is lost while illegal.
    always_comb begin
        onehot_d = onehot_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        if (!legal) begin
            onehot_d = ONEHOT_S0;
            err_d    = 1'b1;
        end else if (tick) begin
            if (up) begin
                onehot_d = {onehot_q[NUM_ST-2:0], onehot_q[NUM_ST-1]};
                wrap_d   = onehot_q[NUM_ST-1];
            end else begin
                onehot_d = {onehot_q[0], onehot_q[NUM_ST-1:1]};
                wrap_d   = onehot_q[0];
            end
        end
`ifdef SCSM_FORCE_EN
        if (force_en) begin
            onehot_d = force_val;
            wrap_d   = 1'b0;
            err_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_q <= ONEHOT_S0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    // Illegal patterns decode to 0 so the display never shows garbage.
    assign state = onehot_to_bin(onehot_q);
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_scsm_counter.sv
// Scoreboard bench for scsm_counter at PRESCALE=4 and PRESCALE=1 driven by shared inputs.
module tb_scsm_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    logic [2:0] state4, state1;
    logic       wrap4, wrap1, err4, err1;

    always #5 clk = ~clk;

`ifdef SCSM_FORCE_EN
    localparam bit HAS_FORCE = 1'b1;
`else
    localparam bit HAS_FORCE = 1'b0;
`endif

    scsm_counter #(.PRESCALE(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
`ifdef SCSM_FORCE_EN
        .force_en (force_en),
        .force_val(force_val),
`endif
        .state    (state4),
        .wrap     (wrap4),
        .err      (err4)
    );

    scsm_counter #(.PRESCALE(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
`ifdef SCSM_FORCE_EN
        .force_en (force_en),
        .force_val(force_val),
`endif
        .state    (state1),
        .wrap     (wrap1),
        .err      (err1)
    );

    // {state4, wrap4, err4, state1, wrap1, err1} expected after the next rising edge
    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: digit index 0..7, illegal flag, prescaler count as plain integers.
    int m_p[2] = '{4, 1};
    int m_idx[2];
    int m_cnt[2];
    bit m_ill[2];
    bit m_wrap[2];
    bit m_err[2];

    task automatic model_step(input bit r, input bit e, input bit u, input bit fe,
                              input logic [7:0] fv);
        bit tick;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_idx[d] = 0; m_ill[d] = 0; m_cnt[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
            end else begin
                tick = e && (m_cnt[d] == m_p[d] - 1);
                if (e) m_cnt[d] = (m_cnt[d] + 1) % m_p[d];
                m_wrap[d] = 0;
                m_err[d]  = 0;
                if (fe && HAS_FORCE) begin
                    if ($countones(fv) == 1) begin
                        m_ill[d] = 0;
                        for (int b = 0; b < 8; b++) if (fv[b]) m_idx[d] = b;
                    end else begin
                        m_ill[d] = 1;
                    end
                end else if (m_ill[d]) begin
                    m_ill[d] = 0; m_idx[d] = 0; m_err[d] = 1;
                end else if (tick) begin
                    if (u) begin
                        m_wrap[d] = (m_idx[d] == 7);
                        m_idx[d]  = (m_idx[d] + 1) % 8;
                    end else begin
                        m_wrap[d] = (m_idx[d] == 0);
                        m_idx[d]  = (m_idx[d] + 7) % 8;
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit fe,
                         input logic [7:0] fv);
        @(negedge clk);
        reset = r; en = e; up = u; force_en = fe; force_val = fv;
        model_step(r, e, u, fe, fv);
        exp_q.push_back({3'(m_ill[0] ? 0 : m_idx[0]), m_wrap[0], m_err[0],
                         3'(m_ill[1] ? 0 : m_idx[1]), m_wrap[1], m_err[1]});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state_p4", int'(state4), int'(e[9:7]));
                chk("wrap_p4",  int'(wrap4),  int'(e[6]));
                chk("err_p4",   int'(err4),   int'(e[5]));
                chk("state_p1", int'(state1), int'(e[4:2]));
                chk("wrap_p1",  int'(wrap1),  int'(e[1]));
                chk("err_p1",   int'(err1),   int'(e[0]));
            end
        end
    end

    initial begin
        logic [7:0] fvals[6] = '{8'b0001_0100, 8'h00, 8'b0010_0000, 8'h81, 8'hff, 8'b1000_0000};

        // Count up from reset across one full wrap
        repeat (2) drive(1, 0, 1, 0, 8'h00);
        repeat (40) drive(0, 1, 1, 0, 8'h00);

        // Count down; then toggle up only on non-tick cycles of the PRESCALE=4 counter
        drive(1, 0, 0, 0, 8'h00);
        repeat (20) drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) drive(0, 1, (m_cnt[0] == 3) ? 1'b0 : i[0], 0, 8'h00);

        // Freeze mid-count at count=2, state=3
        drive(1, 0, 1, 0, 8'h00);
        for (int k = 0; k < 100 && !(m_idx[0] == 3 && m_cnt[0] == 2); k++) drive(0, 1, 1, 0, 8'h00);
        repeat (10) drive(0, 0, 1, 0, 8'h00);
        repeat (6) drive(0, 1, 1, 0, 8'h00);

        // Injected patterns (inputs are ignored by the default build)
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 1, fvals[i]);
            repeat (3) drive(0, 1, 1, 0, 8'h00);
        end

        // Reset coinciding with a tick and a forced illegal value
        for (int k = 0; k < 10 && m_cnt[0] != 3; k++) drive(0, 1, 1, 0, 8'h00);
        drive(1, 1, 1, 1, 8'b0001_0100);
        repeat (6) drive(0, 1, 1, 0, 8'h00);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 15) == 0, 8'($urandom_range(0, 255)));
        end
        drive(0, 1, 1, 0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scsm_counter.md
Name: scsm_counter

Overview:
- Self-correcting 3-bit sequence state machine that produces the digit code driving the board's seven-segment decoder; its `state` output connects directly to that decoder's 3-bit input.
- Internally one-hot (8 flops) and advanced by a prescaled tick, with up/down/hold control.
- Any illegal (non-one-hot) register pattern is detected and recovered to S0 within one clock, with an error pulse.

Parameters:
- PRESCALE, 50_000_000, clock cycles per step tick; must be >= 1 (1 = step every enabled cycle).
- PS_W, $clog2(PRESCALE) (min 1), prescaler counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  1 = prescaler runs and steps are taken; 0 = prescaler and state hold.
- up  input  1  step direction: 1 = S0→S7, 0 = S7→S0; sampled on tick cycles only.
- state  output  3  binary index of the current one-hot state; feeds the seven-segment decoder.
- wrap  output  1  one-cycle pulse on S7→S0 (up) or S0→S7 (down).
- err  output  1  one-cycle pulse per clock in which the one-hot register was illegal.

Interface decision:
- One clock (`clk`); reset (`reset`) is synchronous and active-high.

Behaviour:
- Reset, sampled on `clk` rising edge:
  - one-hot register = 8'b0000_0001 (S0); prescaler = 0; wrap = 0; err = 0.
  - `state` reads 3'b000 in the following cycle.
- Prescaler:
  - When en=1: counts 0..PRESCALE-1, then wraps to 0.
  - tick is internal and combinational: tick = en && (count == PRESCALE-1).
  - When en=0: count holds.
- Step on tick, legal state only:
  - up=1: rotate one-hot left (S7→S0).
  - up=0: rotate right (S0→S7).
  - `state` changes one cycle after the tick cycle.
- Legality: exactly one bit set. Checked every cycle, independent of en and tick.
- Illegal state (zero bits or ≥2 bits set):
  - Next one-hot value = S0.
  - err registers 1 for the next cycle only.
  - Any tick in that cycle is ignored; the prescaler is unaffected.
- `state` encoding:
  - Combinational one-hot→binary conversion.
  - While the register is illegal, `state` = 3'b000, so the display shows 0 and never garbage.
- wrap:
  - Registered; set for the cycle after a tick that moves S7→S0 (up) or S0→S7 (down); otherwise 0.
  - Recovery to S0 never asserts wrap.
- Priority, highest first: reset > force (optional feature) > illegal recovery > tick step > hold.
- Reset mid-count: prescaler restarts at 0. The first tick after reset occurs PRESCALE enabled cycles later.
- Direction change takes effect on the next tick with no extra latency. An up/down toggle between ticks has no effect.
- PRESCALE=1 with en=1 steps every cycle.

Optional Feature:
- Macro: SCSM_FORCE_EN.
- When defined:
  - Adds ports `force_en` (input, 1) and `force_val` (input, 8).
  - When force_en=1, the one-hot register loads `force_val` verbatim next cycle, bypassing the legality check that cycle, so legal or illegal patterns can be injected.
  - The following cycle, normal legality checking applies.
- When undefined:
  - Those ports do not exist.
  - The one-hot register is reachable only through reset, steps and recovery.

Decomposition:
- Package `scsm_pkg`:
  - NUM_ST = 8, ST_W = 3, ONEHOT_S0 = 8'b0000_0001.
  - Function `onehot_to_bin` (returns 0 on illegal input).
  - Function `is_onehot`.
- Sub-module `tick_prescaler`:
  - Parameter PRESCALE; ports clk, reset, en, tick.
  - Reusable by other timed blocks.
- State register, recovery and wrap/err logic stay in `scsm_counter`.

Test Plan (PRESCALE=4 unless noted):
- Reset, en=1, up=1, run 40 cycles → `state` 0,1,…,7,0 changing every 4 cycles; first change 4 cycles after reset release; wrap pulses exactly once, at 7→0.
- up=0 from reset → `state` 0→7→6…; wrap one pulse on 0→7; toggling up between ticks has no effect until the next tick.
- en=0 for 10 cycles mid-count (count=2, state=3) → state and prescaler frozen; after en=1 the next tick comes 2 cycles later and state=4.
- SCSM_FORCE_EN defined: force_val=8'b0001_0100 → `state`=0 that cycle, err=1 next cycle, register=S0; force_val=8'h00 behaves identically; force_val=8'b0010_0000 → state=5, no err.
- reset asserted in the same cycle as a tick and a forced illegal value → next cycle register=S0, prescaler=0, err=0, wrap=0.
- PRESCALE=1, en=1, up=1 → state increments every cycle; wrap every 8th cycle.
